// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code types, conversions and active-low hex segment table
package gray_pkg;
  typedef logic [3:0] nibble_t;
  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };
  function automatic nibble_t gray2bin(nibble_t g);
    nibble_t b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic nibble_t bin2gray(nibble_t b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_rx_decoder_if.sv
// gray_rx_decoder_if: input word, status pulses and segment outputs of the Gray receiver
// Optional pos_count signal present when GRAY_RX_POSCNT_EN is defined.
interface gray_rx_decoder_if #(parameter int W = 4);
  logic [W-1:0] gray_in;
  logic         clear_err;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic         dir_up;
  logic         dir_down;
  logic         err_jump;
  logic         a_seg, b_seg, c_seg, d_seg, e_seg, f_seg, g_seg;
`ifdef GRAY_RX_POSCNT_EN
  logic [7:0]   pos_count;
`endif
  modport master (
    output gray_in, clear_err,
    input  bin_out, bin_valid, dir_up, dir_down, err_jump,
    input  a_seg, b_seg, c_seg, d_seg, e_seg, f_seg, g_seg
`ifdef GRAY_RX_POSCNT_EN
    , input pos_count
`endif
  );
  modport slave (
    input  gray_in, clear_err,
    output bin_out, bin_valid, dir_up, dir_down, err_jump,
    output a_seg, b_seg, c_seg, d_seg, e_seg, f_seg, g_seg
`ifdef GRAY_RX_POSCNT_EN
    , output pos_count
`endif
  );
endinterface

// File: rtl/gray_rx_decoder_seg7.sv
// seg7_hex_decoder: nibble to active-low {a,b,c,d,e,f,g} hex pattern
module seg7_hex_decoder
  import gray_pkg::*;
(
  input  nibble_t    nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG7_HEX[nib_i];
endmodule

// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: synchronize, debounce and decode a Gray word; classify steps; drive hex digit
// Define GRAY_RX_POSCNT_EN to add an 8-bit signed-step position counter (pos_count).
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic               clk,
  input logic               rst_n,
  gray_rx_decoder_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [W-1:0]     s1_q, s2_q, cand_q, stable_q, bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q, up_q, down_q, err_q;
  logic             commit_d, up_d, down_d;
  logic [6:0]       seg;
`ifdef GRAY_RX_POSCNT_EN
  logic [7:0]       pos_q;
  assign bus.pos_count = pos_q;
`endif
  always_comb begin
    bin_d[W-1] = cand_q[W-1];
    for (int i = W - 2; i >= 0; i--) bin_d[i] = bin_d[i+1] ^ cand_q[i];
    commit_d = (s2_q == cand_q) && (cnt_q == CNT_MAX) && (cand_q != stable_q);
    up_d     = bin_d == bin_q + W'(1);
    down_d   = bin_d == bin_q - W'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef GRAY_RX_POSCNT_EN
      pos_q    <= '0;
`endif
    end else begin
      s1_q    <= bus.gray_in;
      s2_q    <= s1_q;
      cand_q  <= s2_q;
      cnt_q   <= (s2_q != cand_q) ? '0 : (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
      valid_q <= commit_d;
      up_q    <= commit_d && up_d;
      down_q  <= commit_d && down_d;
      // A jump on the same edge as clear_err must still be reported
      err_q   <= (commit_d && !up_d && !down_d) ? 1'b1 : bus.clear_err ? 1'b0 : err_q;
      if (commit_d) begin
        stable_q <= cand_q;
        bin_q    <= bin_d;
`ifdef GRAY_RX_POSCNT_EN
        pos_q    <= pos_q + (up_d ? 8'd1 : down_d ? 8'hFF : 8'd0);
`endif
      end
    end
  end
  seg7_hex_decoder u_seg (.nib_i(bin_q), .seg_o(seg));
  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = valid_q;
  assign bus.dir_up    = up_q;
  assign bus.dir_down  = down_q;
  assign bus.err_jump  = err_q;
  assign {bus.a_seg, bus.b_seg, bus.c_seg, bus.d_seg, bus.e_seg, bus.f_seg, bus.g_seg} = seg;
endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb_gray_rx_decoder: directed vectors for gray_rx_decoder with DEBOUNCE_CYCLES=4
module tb_gray_rx_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [6:0] seg_w;
  localparam logic [6:0] SEG_EXP [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };
  always #5 clk = ~clk;
  gray_rx_decoder_if #(.W(4)) bus ();
  gray_rx_decoder #(.W(4), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign seg_w = {bus.a_seg, bus.b_seg, bus.c_seg, bus.d_seg, bus.e_seg, bus.f_seg, bus.g_seg};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic commit_wait(input string tag, input logic [3:0] b, input logic up, input logic dn,
                             input logic err, input logic clr);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check({tag, "/quiet"}, {31'd0, bus.bin_valid}, 32'd0);
    end
    if (clr) bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    check({tag, "/valid"}, {31'd0, bus.bin_valid}, 32'd1);
    check({tag, "/bin"}, {28'd0, bus.bin_out}, {28'd0, b});
    check({tag, "/up"}, {31'd0, bus.dir_up}, {31'd0, up});
    check({tag, "/down"}, {31'd0, bus.dir_down}, {31'd0, dn});
    check({tag, "/err"}, {31'd0, bus.err_jump}, {31'd0, err});
    check({tag, "/seg"}, {25'd0, seg_w}, {25'd0, SEG_EXP[b]});
    @(negedge clk);
    check({tag, "/pulse_end"}, {29'd0, bus.bin_valid, bus.dir_up, bus.dir_down}, 32'd0);
    check({tag, "/err_hold"}, {31'd0, bus.err_jump}, {31'd0, err});
  endtask
  task automatic apply(input string tag, input logic [3:0] g, input logic [3:0] b, input logic up,
                       input logic dn, input logic err, input logic clr);
    @(negedge clk);
    bus.gray_in = g;
    commit_wait(tag, b, up, dn, err, clr);
  endtask
  task automatic pulse_clear(input string tag);
    @(negedge clk);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    check(tag, {31'd0, bus.err_jump}, 32'd0);
  endtask
  initial begin
    bus.gray_in = 4'b0110;
    bus.clear_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/bin", {28'd0, bus.bin_out}, 32'd0);
    check("rst/seg", {25'd0, seg_w}, 32'h01);
    check("rst/flags", {28'd0, bus.bin_valid, bus.dir_up, bus.dir_down, bus.err_jump}, 32'd0);
    rst_n = 1'b1;
    commit_wait("rst_release", 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    apply("to_zero", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clear("clear1");
    apply("step_up", 4'b0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("step_down", 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply("wrap_down", 4'b1000, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    apply("wrap_up", 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("wrap_down2", 4'b1000, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    apply("wrap_up2", 4'b0000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("bounce_base", 4'b0001, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.gray_in = (i % 2 == 0) ? 4'b0011 : 4'b0001;
      check("bounce/quiet_a", {31'd0, bus.bin_valid}, 32'd0);
      @(negedge clk);
      check("bounce/quiet_b", {31'd0, bus.bin_valid}, 32'd0);
    end
    apply("bounce_settle", 4'b0011, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    apply("back1", 4'b0001, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply("back0", 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply("jump", 4'b0010, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse_clear("clear2");
    apply("jump_clr", 4'b0000, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    bus.gray_in = 4'b0001;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst/quiet", {28'd0, bus.bin_valid, bus.dir_up, bus.dir_down, bus.err_jump}, 32'd0);
      check("mid_rst/bin", {28'd0, bus.bin_out}, 32'd0);
    end
    rst_n = 1'b1;
    commit_wait("mid_rst_release", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gray_rx_decoder.md
Name: gray_rx_decoder

Overview:
- Receiver end of the Gray-code path: takes a 4-bit Gray-coded word from an external source (switches or an encoder bus).
- Synchronizes and debounces the word, then converts it back to binary.
- Classifies each accepted change as a +1 step, a -1 step or an illegal jump.
- Drives the binary value as hex onto an active-low 7-segment digit.

Parameters:
- W, 4, Gray/binary word width; the segment decode is defined only for W=4.
- DEBOUNCE_CYCLES, 50000, number of consecutive clocks the synchronized input must hold before it is accepted; legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the debounce counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- gray_in  in  W  asynchronous Gray-coded input word.
- clear_err  in  1  synchronous clear of err_jump.
- bin_out  out  W  last accepted value, converted to binary.
- bin_valid  out  1  one-cycle pulse when bin_out updates.
- dir_up  out  1  one-cycle pulse; accepted value = previous + 1 mod 16 (15→0 included).
- dir_down  out  1  one-cycle pulse; accepted value = previous − 1 mod 16 (0→15 included).
- err_jump  out  1  sticky flag: an accepted value was not adjacent to the previous one.
- a_seg, b_seg, c_seg, d_seg, e_seg, f_seg, g_seg  out  1 each  active-low segments showing bin_out as hex 0–F.

Behaviour:
- Reset (async assert, sync release): sync FFs, candidate, counter and stable value all 0; bin_out=0; bin_valid, dir_up, dir_down, err_jump = 0; segments show "0" (a..f=0, g=1).
- Input path: two-FF synchronizer s1→s2 on gray_in.
- Debounce, evaluated every clock:
  - If s2≠cand: cand←s2, cnt←0.
  - Else if cnt<DEBOUNCE_CYCLES−1: cnt←cnt+1.
  - Else if cand≠stable: commit. Otherwise hold.
- Commit (single cycle). All outputs are registered and update on the commit edge:
  - stable←cand.
  - bin_out←g2b(cand), where b[W−1]=g[W−1] and b[i]=b[i+1]^g[i].
  - bin_valid←1.
  - dir_up←(g2b(cand)==bin_out+1).
  - dir_down←(g2b(cand)==bin_out−1). Arithmetic is W-bit modular.
  - If neither dir_up nor dir_down: err_jump←1. Jumps of ±2 or more are errors, including single-bit Gray changes that are non-adjacent (e.g. 0000→0010, bin 0→3).
  - Segments←hex pattern of the new bin_out.
- bin_valid, dir_up and dir_down are 0 on every non-commit cycle.
- Latency: counting edge 1 as the first edge that samples the new gray_in, commit occurs at edge DEBOUNCE_CYCLES+3, provided gray_in is held throughout.
- Any change of s2 before commit restarts the count. Glitches shorter than DEBOUNCE_CYCLES produce no output activity.
- A change that returns to the already-stable value produces no commit.
- err_jump: set has priority over clear_err when both occur in the same cycle; otherwise clear_err←0 clears it. Only reset or clear_err clears it.
- rst_n asserted mid-debounce: the pending candidate is discarded. After release, the input is re-acquired from 0 state; a non-zero held input commits DEBOUNCE_CYCLES+3 edges after release.

Optional Feature:
- GRAY_RX_POSCNT_EN defined: adds output port pos_count[7:0], reset to 0.
  - +1 on dir_up, −1 on dir_down, wraps mod 256.
  - Unchanged on an error commit.
- GRAY_RX_POSCNT_EN undefined: port and logic absent; everything else is identical.

Decomposition:
- Package gray_pkg:
  - typedef logic [3:0] nibble_t.
  - Function gray2bin, plus its inverse bin2gray for benches.
  - Constant SEG7_HEX[16] of active-low {a,b,c,d,e,f,g} patterns.
- Sub-module seg7_hex_decoder (nibble_t in, 7 active-low segments out, purely combinational from the package table). It is instantiated on bin_out; shared with the other display blocks.

Test Plan (DEBOUNCE_CYCLES=4):
1. rst_n=0 with gray_in=0110 → bin_out=0, segs a..f=0, g=1, all pulses/err 0. After release and 7 edges → bin_out=4, err_jump=1.
2. From stable 0000, set gray_in=0001 → exactly at edge 7: bin_out=1, bin_valid=1 and dir_up=1 for one cycle; segs b,c=0, others 1.
3. Wrap: stable 1000 (bin 15) → 0000: bin_out=0, dir_up pulse, err_jump stays 0. Then 0000→1000: dir_down pulse.
4. Bounce: from stable 0001, toggle gray_in 0001↔0011 every 2 cycles for 20 cycles, then hold 0011 → no pulses during toggling; one commit at bin_out=2 at edge 7 after the last change.
5. Jump: stable 0000 → 0010 → bin_out=3, err_jump=1, no dir pulse. Pulse clear_err → err_jump=0. clear_err coincident with a jump commit → err_jump=1.
6. Reset mid-debounce: gray_in=0001 held, rst_n pulsed low at edge 4 → no commit before release; commit to bin_out=1 at the 7th edge after release.
